// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 16-point in-place radix-2 FFT sequencers:
// transform-size constants, stage/butterfly/address index widths, the
// write-back FSM state enum and the (stage, butterfly) -> (A, B) address map
// used by both the read side and the write-back side.
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_STAGES = 4;
    localparam int FFT_BFLY   = 8;

    localparam int STAGE_W = 2;
    localparam int BFLY_W  = 3;
    localparam int ADDR_W  = $clog2(FFT_N);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fft_state_e;

    // A is the bit-reversed butterfly index {b0, b1, b2} with a 0 inserted at
    // bit position (3 - stage); the partner B sets that same bit.
    function automatic logic [ADDR_W-1:0] fft_addr_a(
        input logic [STAGE_W-1:0] stage,
        input logic [BFLY_W-1:0]  bfly
    );
        logic [ADDR_W-1:0] a;
        case (stage)
            2'd0:    a = {1'b0, bfly[0], bfly[1], bfly[2]};
            2'd1:    a = {bfly[0], 1'b0, bfly[1], bfly[2]};
            2'd2:    a = {bfly[0], bfly[1], 1'b0, bfly[2]};
            default: a = {bfly[0], bfly[1], bfly[2], 1'b0};
        endcase
        return a;
    endfunction

    function automatic logic [ADDR_W-1:0] fft_addr_b(
        input logic [STAGE_W-1:0] stage,
        input logic [BFLY_W-1:0]  bfly
    );
        return fft_addr_a(stage, bfly) | (ADDR_W'(FFT_N / 2) >> stage);
    endfunction

endpackage

// File: rtl/fft_wr_addr_map.sv
// ----------------------------------------------------------------------------
// fft_wr_addr_map
// Combinational map from (stage, butterfly) to the A/B working-memory
// addresses of that butterfly.
// Ports:
//   stage  in  STAGE_W  current stage 0..3
//   bfly   in  BFLY_W   butterfly index 0..7
//   addr_a out ADDR_W   upper (A) address
//   addr_b out ADDR_W   lower (B) address, A | span
// ----------------------------------------------------------------------------
module fft_wr_addr_map
    import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [BFLY_W-1:0]  bfly,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b
);

    always_comb begin
        addr_a = fft_addr_a(stage, bfly);
        addr_b = fft_addr_b(stage, bfly);
    end

endmodule

// File: rtl/fft_wb_addr_gen.sv
// ----------------------------------------------------------------------------
// fft_wb_addr_gen
// Write-back sequencer for the 16-point in-place radix-2 FFT. Registers each
// butterfly result pair and issues one dual-port memory write per beat at the
// A/B addresses of the current stage/butterfly, counting butterflies and
// stages and pulsing stage/transform completion.
//
// Build option: define FFT_WB_SCALE_EN to arithmetic-shift every re/im
// component of the write data right by one bit on every stage.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a transform (honoured only in IDLE)
//   bf_valid      butterfly result pair valid
//   bf_a, bf_b    butterfly outputs {re, im}
//   mem_we        write strobe for both memory ports
//   mem_addr_a/b  write addresses
//   mem_wdata_a/b write data
//   wr_stage      stage of the next expected beat
//   wr_bfly       butterfly index of the next expected beat
//   stage_done    pulse with the write of butterfly 7 of a stage
//   fft_done      pulse with the final write of the transform
//   busy          high while in RUN
//   seq_err       pulse when a beat arrives outside RUN
// ----------------------------------------------------------------------------
module fft_wb_addr_gen
    import fft_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                bf_valid,
    input  logic [2*DW-1:0]     bf_a,
    input  logic [2*DW-1:0]     bf_b,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr_a,
    output logic [ADDR_W-1:0]   mem_addr_b,
    output logic [2*DW-1:0]     mem_wdata_a,
    output logic [2*DW-1:0]     mem_wdata_b,
    output logic [STAGE_W-1:0]  wr_stage,
    output logic [BFLY_W-1:0]   wr_bfly,
    output logic                stage_done,
    output logic                fft_done,
    output logic                busy,
    output logic                seq_err
);

    fft_state_e          state_q, state_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [BFLY_W-1:0]   bfly_q, bfly_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [2*DW-1:0]     wdata_a_q, wdata_a_d;
    logic [2*DW-1:0]     wdata_b_q, wdata_b_d;
    logic                stage_done_q, stage_done_d;
    logic                fft_done_q, fft_done_d;
    logic                seq_err_q, seq_err_d;

    logic [ADDR_W-1:0]   map_a;
    logic [ADDR_W-1:0]   map_b;
    logic [2*DW-1:0]     data_a;
    logic [2*DW-1:0]     data_b;

    fft_wr_addr_map u_addr_map (
        .stage  (stage_q),
        .bfly   (bfly_q),
        .addr_a (map_a),
        .addr_b (map_b)
    );

`ifdef FFT_WB_SCALE_EN
    // Each component is halved independently so the sign of re and im is
    // preserved; four stages give an overall 1/16 scale.
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    always_comb begin
        a_re   = $signed(bf_a[2*DW-1:DW]);
        a_im   = $signed(bf_a[DW-1:0]);
        b_re   = $signed(bf_b[2*DW-1:DW]);
        b_im   = $signed(bf_b[DW-1:0]);
        data_a = {a_re >>> 1, a_im >>> 1};
        data_b = {b_re >>> 1, b_im >>> 1};
    end
`else
    always_comb begin
        data_a = bf_a;
        data_b = bf_b;
    end
`endif

    wire last_bfly  = (bfly_q  == BFLY_W'(FFT_BFLY - 1));
    wire last_stage = (stage_q == STAGE_W'(FFT_STAGES - 1));

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        bfly_d       = bfly_q;
        we_d         = 1'b0;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        wdata_a_d    = wdata_a_q;
        wdata_b_d    = wdata_b_q;
        stage_done_d = 1'b0;
        fft_done_d   = 1'b0;
        seq_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A beat colliding with the accepted start is still a beat
                // outside RUN, so it is flagged and never written.
                seq_err_d = bf_valid;
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            default: begin
                if (bf_valid) begin
                    we_d      = 1'b1;
                    addr_a_d  = map_a;
                    addr_b_d  = map_b;
                    wdata_a_d = data_a;
                    wdata_b_d = data_b;
                    bfly_d    = bfly_q + BFLY_W'(1);
                    if (last_bfly) begin
                        stage_done_d = 1'b1;
                        stage_d      = stage_q + STAGE_W'(1);
                        if (last_stage) begin
                            fft_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            stage_q      <= '0;
            bfly_q       <= '0;
            we_q         <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            wdata_a_q    <= '0;
            wdata_b_q    <= '0;
            stage_done_q <= 1'b0;
            fft_done_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            bfly_q       <= bfly_d;
            we_q         <= we_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            wdata_a_q    <= wdata_a_d;
            wdata_b_q    <= wdata_b_d;
            stage_done_q <= stage_done_d;
            fft_done_q   <= fft_done_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_addr_a  = addr_a_q;
    assign mem_addr_b  = addr_b_q;
    assign mem_wdata_a = wdata_a_q;
    assign mem_wdata_b = wdata_b_q;
    assign wr_stage    = stage_q;
    assign wr_bfly     = bfly_q;
    assign stage_done  = stage_done_q;
    assign fft_done    = fft_done_q;
    assign busy        = (state_q == ST_RUN);
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_fft_wb_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_fft_wb_addr_gen
// Table-driven bench for fft_wb_addr_gen. Each record holds the inputs for
// one clock cycle and the outputs expected just after that edge. Covers
// reset, stray beats, start collisions, a back-to-back transform, a gapped
// transform, a mid-run reset and the write-data scaling option
// (FFT_WB_SCALE_EN).
// ----------------------------------------------------------------------------
module tb_fft_wb_addr_gen;

    localparam int DW = 16;

    typedef struct {
        logic        rst;
        logic        start;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        e_we;
        logic        e_busy;
        logic        e_seq;
        logic        e_sd;
        logic        e_fd;
        logic [1:0]  e_stage;
        logic [2:0]  e_bfly;
        logic [3:0]  e_aa;
        logic [3:0]  e_ab;
        logic [31:0] e_da;
        logic [31:0] e_db;
        logic        chk_all;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              bf_valid = 1'b0;
    logic [2*DW-1:0]   bf_a = '0;
    logic [2*DW-1:0]   bf_b = '0;
    logic              mem_we;
    logic [3:0]        mem_addr_a;
    logic [3:0]        mem_addr_b;
    logic [2*DW-1:0]   mem_wdata_a;
    logic [2*DW-1:0]   mem_wdata_b;
    logic [1:0]        wr_stage;
    logic [2:0]        wr_bfly;
    logic              stage_done;
    logic              fft_done;
    logic              busy;
    logic              seq_err;

    int passCount = 0;
    int totalCount = 0;
    int vecIdx = 0;
    vec_t vecs[$];

    // Hand-derived A addresses per stage and butterfly, and the B offset.
    int aTab [4][8] = '{
        '{0, 4, 2, 6, 1, 5, 3, 7},
        '{0, 8, 2, 10, 1, 9, 3, 11},
        '{0, 8, 4, 12, 1, 9, 5, 13},
        '{0, 8, 4, 12, 2, 10, 6, 14}
    };
    int spanTab [4] = '{8, 4, 2, 1};

    fft_wb_addr_gen #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bf_valid    (bf_valid),
        .bf_a        (bf_a),
        .bf_b        (bf_b),
        .mem_we      (mem_we),
        .mem_addr_a  (mem_addr_a),
        .mem_addr_b  (mem_addr_b),
        .mem_wdata_a (mem_wdata_a),
        .mem_wdata_b (mem_wdata_b),
        .wr_stage    (wr_stage),
        .wr_bfly     (wr_bfly),
        .stage_done  (stage_done),
        .fft_done    (fft_done),
        .busy        (busy),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expData(input logic [31:0] d);
`ifdef FFT_WB_SCALE_EN
        logic signed [15:0] re;
        logic signed [15:0] im;
        re = d[31:16];
        im = d[15:0];
        return {re >>> 1, im >>> 1};
`else
        return d;
`endif
    endfunction

    function automatic vec_t mkIdle(input logic r, input logic st, input logic v,
                                    input logic eb, input logic es,
                                    input logic [1:0] s, input logic [2:0] bf,
                                    input logic ca);
        vec_t x;
        x = '{default: '0};
        x.rst = r; x.start = st; x.valid = v;
        x.a = 32'hDEAD_BEEF; x.b = 32'h1234_5678;
        x.e_busy = eb; x.e_seq = es; x.e_stage = s; x.e_bfly = bf;
        x.chk_all = ca;
        return x;
    endfunction

    function automatic vec_t mkBeat(input int s, input int b, input logic st,
                                    input logic [31:0] da, input logic [31:0] db);
        vec_t x;
        x = '{default: '0};
        x.valid = 1'b1; x.start = st; x.a = da; x.b = db;
        x.e_we = 1'b1;
        x.e_aa = 4'(aTab[s][b]);
        x.e_ab = 4'(aTab[s][b] | spanTab[s]);
        x.e_da = expData(da);
        x.e_db = expData(db);
        x.e_sd = (b == 7);
        x.e_fd = (s == 3 && b == 7);
        x.e_busy = !(s == 3 && b == 7);
        x.e_bfly = 3'(b + 1);
        x.e_stage = (b == 7) ? 2'(s + 1) : 2'(s);
        return x;
    endfunction

    function automatic logic [31:0] dataA(input int idx);
        return {16'h8000 + 16'(idx * 1031), 16'h0003 - 16'(idx * 7)};
    endfunction

    function automatic logic [31:0] dataB(input int idx);
        return {16'(idx * 613), 16'hF00F ^ 16'(idx)};
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s (vector %0d): got %0h expected %0h", name, vecIdx, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst;
        start = v.start;
        bf_valid = v.valid;
        bf_a = v.a;
        bf_b = v.b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        checkField("mem_we", 32'(mem_we), 32'(v.e_we));
        checkField("busy", 32'(busy), 32'(v.e_busy));
        checkField("seq_err", 32'(seq_err), 32'(v.e_seq));
        checkField("stage_done", 32'(stage_done), 32'(v.e_sd));
        checkField("fft_done", 32'(fft_done), 32'(v.e_fd));
        checkField("wr_stage", 32'(wr_stage), 32'(v.e_stage));
        checkField("wr_bfly", 32'(wr_bfly), 32'(v.e_bfly));
        if (v.e_we || v.chk_all) begin
            checkField("mem_addr_a", 32'(mem_addr_a), 32'(v.e_aa));
            checkField("mem_addr_b", 32'(mem_addr_b), 32'(v.e_ab));
            checkField("mem_wdata_a", mem_wdata_a, v.e_da);
            checkField("mem_wdata_b", mem_wdata_b, v.e_db);
        end
    endtask

    initial begin
        vec_t v;
        int idx;
        int gaps;

        // Reset with junk on every input, then idle stray beat and collision.
        vecs.push_back(mkIdle(1, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mkIdle(1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkIdle(0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mkIdle(0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkIdle(0, 1, 1, 1, 1, 0, 0, 1));

        // Back-to-back transform; a start mid-run must be ignored.
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 8; b++) begin
                idx = s * 8 + b;
                v = mkBeat(s, b, (s == 1 && b == 2), dataA(idx), dataB(idx));
                if (idx == 0) begin
`ifdef FFT_WB_SCALE_EN
                    v.e_da = {16'shC000, 16'sh0001};
`else
                    v.e_da = {16'sh8000, 16'sh0003};
`endif
                end
                vecs.push_back(v);
            end
        end

        // Start sampled in the fft_done cycle, then a gapped transform.
        vecs.push_back(mkIdle(0, 1, 0, 1, 0, 0, 0, 0));
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 8; b++) begin
                gaps = $urandom_range(1, 3);
                for (int g = 0; g < gaps; g++)
                    vecs.push_back(mkIdle(0, 0, 0, 1, 0, 2'(s), 3'(b), 0));
                idx = 40 + s * 8 + b;
                vecs.push_back(mkBeat(s, b, 1'b0, dataA(idx), dataB(idx)));
            end
        end
        vecs.push_back(mkIdle(0, 0, 0, 0, 0, 0, 0, 0));

        // Abort after 11 beats, then restart from stage 0, butterfly 0.
        vecs.push_back(mkIdle(0, 1, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 11; k++)
            vecs.push_back(mkBeat(k / 8, k % 8, 1'b0, dataA(80 + k), dataB(80 + k)));
        vecs.push_back(mkIdle(1, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mkIdle(0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkIdle(0, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mkBeat(0, 0, 1'b0, dataA(99), dataB(99)));
        vecs.push_back(mkIdle(0, 0, 0, 1, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            vecIdx = i;
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
